// File: rtl/fas_pkg.sv
// -----------------------------------------------------------------------------
// fas_pkg
// Shared definitions for the full adder/subtractor datapath and the sequential
// divider built on top of it.
//   DIV_WIDTH          default operand/result width
//   div_state_t        divider FSM state encoding (IDLE, RUN, FIX, DONE)
//   T_OR/T_NOT/T_XOR   nominal primitive gate delays (ps) for gate-level models;
//                      the synthesizable RTL does not use them
// -----------------------------------------------------------------------------
package fas_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int T_OR  = 20;
  localparam int T_NOT = 10;
  localparam int T_XOR = 30;

endpackage

// File: rtl/addsub_n.sv
// -----------------------------------------------------------------------------
// addsub_n
// N-bit ripple-carry chain of full adder/subtractor cells.
//   a, b   [N-1:0]  operands
//   a_ns   1        1 = add (a + b), 0 = subtract (a - b)
//   sum    [N-1:0]  result
//   cout   1        carry out; in subtract mode cout = 1 means no borrow
// -----------------------------------------------------------------------------
module addsub_n
  import fas_pkg::*;
#(
  parameter int N = DIV_WIDTH
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         a_ns,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0]   c;
  logic [N-1:0] b_eff;

  // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
  assign c[0] = ~a_ns;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign b_eff[i]  = b[i] ^ ~a_ns;
    assign sum[i]    = a[i] ^ b_eff[i] ^ c[i];
    assign c[i+1]    = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
  end

  assign cout = c[N];

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Sequential restoring divider, one quotient bit per clock, using an addsub_n
// chain in subtract mode for the trial subtraction.
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request, sampled only in IDLE
//   dividend     [N-1:0] numerator, captured on accepted start
//   divisor      [N-1:0] denominator, captured on accepted start
//   busy         high from the cycle after accept through the done cycle
//   done         one-cycle pulse, results valid
//   quotient     [N-1:0] held until next accepted start
//   remainder    [N-1:0] held until next accepted start
//   div_by_zero  set with done when the captured divisor was zero
// Build option: SEQ_DIVIDER_SIGNED_EN selects two's complement operands with
// truncation toward zero (adds a FIX state, one extra cycle of latency).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; the done pulse is visible in this state
// RUN   | one trial subtraction per cycle, N cycles
// FIX   | sign correction of magnitudes (signed build only)
// DONE  | publish results; done/outputs register on the next edge
// -----------------------------------------------------------------------------
module seq_divider
  import fas_pkg::*;
#(
  parameter int N = DIV_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  div_state_t    state;
  logic [N:0]    pr;       // partial remainder, one extra bit for the shift-out
  logic [N-1:0]  dvd;      // dividend shift register, MSB feeds the remainder
  logic [N-1:0]  dvs;
  logic [N-1:0]  q;
  logic [CW-1:0] cnt;
  logic          dz;

  logic [N:0]    shifted;
  logic [N-1:0]  diff;
  logic          no_borrow;
  logic          fits;
  logic          pr_msb_unused;

  logic [N-1:0]  dvd_in;
  logic [N-1:0]  dvs_in;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic q_neg;
  logic r_neg;

  assign dvd_in = dividend[N-1] ? (~dividend + 1'b1) : dividend;
  assign dvs_in = divisor[N-1]  ? (~divisor + 1'b1)  : divisor;
`else
  assign dvd_in = dividend;
  assign dvs_in = divisor;
`endif

  // After every RUN step the remainder is below the divisor, so pr[N] stays
  // clear; the bit shifted out of pr[N-1] lands in shifted[N].
  assign shifted       = {pr[N-1:0], dvd[N-1]};
  assign pr_msb_unused = pr[N];

  addsub_n #(.N(N)) u_sub (
    .a    (shifted[N-1:0]),
    .b    (dvs),
    .a_ns (1'b0),
    .sum  (diff),
    .cout (no_borrow)
  );

  // If the shifted-out bit is set the value is >= 2^N > divisor, so the
  // subtraction succeeds even though the N-bit chain reports a borrow.
  assign fits = shifted[N] | no_borrow;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      pr          <= '0;
      dvd         <= '0;
      dvs         <= '0;
      q           <= '0;
      cnt         <= '0;
      dz          <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            busy        <= 1'b1;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= CW'(N - 1);
            dvd         <= dvd_in;
            dvs         <= dvs_in;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg       <= dividend[N-1] ^ divisor[N-1];
            r_neg       <= dividend[N-1];
`endif
            if (divisor == '0) begin
              // Results are preloaded so DONE can publish them unchanged.
              q     <= '1;
              pr    <= {1'b0, dividend};
              dz    <= 1'b1;
              state <= DONE;
            end else begin
              q     <= '0;
              pr    <= '0;
              dz    <= 1'b0;
              state <= RUN;
            end
          end
        end

        RUN: begin
          pr  <= fits ? {1'b0, diff} : shifted;
          q   <= {q[N-2:0], fits};
          dvd <= {dvd[N-2:0], 1'b0};
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            state <= FIX;
`else
            state <= DONE;
`endif
          end
        end

`ifdef SEQ_DIVIDER_SIGNED_EN
        FIX: begin
          // Most-negative / -1 yields magnitude 2^(N-1), which already reads
          // back as the most-negative value, so the wrap needs no special case.
          if (q_neg) q <= ~q + 1'b1;
          if (r_neg) pr <= {1'b0, ~pr[N-1:0] + 1'b1};
          state <= DONE;
        end
`endif

        DONE: begin
          quotient    <= q;
          remainder   <= pr[N-1:0];
          div_by_zero <= dz;
          done        <= 1'b1;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed bench for seq_divider (N = 8). Build with SEQ_DIVIDER_SIGNED_EN to
// exercise the signed variant; expectations switch accordingly.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int N = 8;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam int LAT = N + 2;
`else
  localparam int LAT = N + 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int n_run  = 0;
  int n_fail = 0;
  int lat;
  int done_seen;

  always #5 clk = ~clk;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Drives start for one edge, then counts edges until
  // done is seen (lat = edges after the accept edge). Optionally pulses a
  // second start with other operands after inj edges.
  task automatic run_div(input logic [N-1:0] dd, input logic [N-1:0] dv,
                         input int inj, output int l);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    l = 0;
    while (l < 40) begin
      @(posedge clk);
      #1 start = 1'b0;
      l++;
      @(negedge clk);
      if (done) break;
      if (l == inj) begin
        start    = 1'b1;
        dividend = 8'hC8;
        divisor  = 8'h03;
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    run_div(8'd100, 8'd7, -1, lat);
    chk("d100_7_lat", lat, LAT);
    chk("d100_7_quot", quotient, 8'd14);
    chk("d100_7_rem", remainder, 8'd2);
    chk("d100_7_dz", div_by_zero, 0);
    chk("done_cycle_busy", busy, 1);

    // back-to-back: start presented in the done cycle
    run_div(8'd255, 8'd1, -1, lat);
    chk("d255_1_lat", lat, LAT);
`ifdef SEQ_DIVIDER_SIGNED_EN
    chk("d255_1_quot", quotient, 8'hFF);
`else
    chk("d255_1_quot", quotient, 8'd255);
`endif
    chk("d255_1_rem", remainder, 8'd0);

    run_div(8'd5, 8'd9, -1, lat);
    chk("d5_9_lat", lat, LAT);
    chk("d5_9_quot", quotient, 8'd0);
    chk("d5_9_rem", remainder, 8'd5);

    repeat (3) @(negedge clk);
    chk("hold_quot", quotient, 8'd0);
    chk("hold_rem", remainder, 8'd5);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    run_div(8'h3C, 8'h00, -1, lat);
    chk("dz_lat", lat, 1);
    chk("dz_flag", div_by_zero, 1);
    chk("dz_quot", quotient, 8'hFF);
    chk("dz_rem", remainder, 8'h3C);

    @(negedge clk);
    run_div(8'd200, 8'd3, -1, lat);
    chk("d200_3_lat", lat, LAT);
    chk("d200_3_dz", div_by_zero, 0);
`ifdef SEQ_DIVIDER_SIGNED_EN
    chk("d200_3_quot", quotient, 8'hEE);
    chk("d200_3_rem", remainder, 8'hFE);
`else
    chk("d200_3_quot", quotient, 8'd66);
    chk("d200_3_rem", remainder, 8'd2);
`endif

    @(negedge clk);
    run_div(8'd100, 8'd7, 3, lat);
    chk("inject_lat", lat, LAT);
    chk("inject_quot", quotient, 8'd14);
    chk("inject_rem", remainder, 8'd2);
    // the first post-done edge must not see a stale start
    @(negedge clk);
    chk("inject_no_restart", busy, 0);

    // reset during RUN cycle 4
    dividend = 8'd255;
    divisor  = 8'd1;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_quot", quotient, 0);
    chk("midrst_rem", remainder, 0);
    chk("midrst_dz", div_by_zero, 0);
    rst = 1'b0;
    done_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("midrst_no_done", done_seen, 0);

    // start together with rst is dropped
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd2;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", busy, 0);
    done_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    chk("rst_start_no_op", done_seen, 0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    run_div(8'hF9, 8'h02, -1, lat);
    chk("s_m7_2_lat", lat, LAT);
    chk("s_m7_2_quot", quotient, 8'hFD);
    chk("s_m7_2_rem", remainder, 8'hFF);

    run_div(8'h80, 8'hFF, -1, lat);
    chk("s_min_m1_lat", lat, LAT);
    chk("s_min_m1_quot", quotient, 8'h80);
    chk("s_min_m1_rem", remainder, 8'h00);
    chk("s_min_m1_dz", div_by_zero, 0);

    run_div(8'h85, 8'h00, -1, lat);
    chk("s_dz_quot", quotient, 8'hFF);
    chk("s_dz_rem", remainder, 8'h85);
    chk("s_dz_flag", div_by_zero, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
